// File: rtl/pipe_reg_hs_pkg.sv
// Shared definitions for the handshaked pipeline register family.
// Carries the default beat widths, the NOP/initial value that empty
// pipeline slots present, and the occupancy state encodings used by the
// control FSM in pipe_reg_hs.
package pipe_reg_hs_pkg;

    // Default instruction/payload width and the value an empty slot shows.
    localparam int              LENGTH      = 32;
    localparam logic [31:0]     INITIAL_VAL = 32'h0000_0000;

    // Default PC field width and the resulting full beat width.
    localparam int              PC_LENGTH   = 32;
    localparam int              BEAT_LENGTH = LENGTH + PC_LENGTH;

    // Occupancy states: the encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    // A zero-width PC field is carried as a single constant-zero bit so
    // that port declarations stay legal.
    function automatic int pc_width_eff(input int pc_w);
        return (pc_w > 0) ? pc_w : 1;
    endfunction

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Bundle of the upstream and downstream handshake signals of
// pipe_reg_hs, plus flush and the occupancy debug output.
//   slave  : view of the pipeline register itself
//   master : view of the environment driving it (stages around it)
// Signals:
//   flush                      discard held and incoming beats
//   in_valid/in_ready          upstream handshake
//   in_data/in_pc              upstream beat
//   out_valid/out_ready        downstream handshake
//   out_data/out_pc            downstream beat
//   occupancy                  held entries (0..2)
// With PC_W = 0 the pc signals shrink to one bit that always reads zero.
interface pipe_reg_hs_if
    import pipe_reg_hs_pkg::*;
#(
    parameter int DATA_W = LENGTH,
    parameter int PC_W   = PC_LENGTH
);

    localparam int PCW = pc_width_eff(PC_W);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PCW-1:0]    in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PCW-1:0]    out_pc;
    logic [1:0]        occupancy;

    modport slave (
        input  flush, in_valid, in_data, in_pc, out_ready,
        output in_ready, out_valid, out_data, out_pc, occupancy
    );

    modport master (
        output flush, in_valid, in_data, in_pc, out_ready,
        input  in_ready, out_valid, out_data, out_pc, occupancy
    );

endinterface

// File: rtl/pipe_reg_hs_slot.sv
// pipe_slot: one valid + data + pc register of the pipeline register.
// Clearing (or reset) empties the slot and parks the data at NOP_VAL and
// the pc at zero, so an empty slot never shows stale contents.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clear                 empty the slot (wins over load)
//   load                  capture load_data/load_pc and mark valid
//   load_data, load_pc    beat to capture
//   valid, data, pc       slot contents
module pipe_slot
    import pipe_reg_hs_pkg::*;
#(
    parameter int                DATA_W  = LENGTH,
    parameter int                PC_W    = PC_LENGTH,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(INITIAL_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [PC_W-1:0]   load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [PC_W-1:0]   pc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            data  <= NOP_VAL;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: valid/ready pipeline register carrying an instruction and
// its PC between two stages (IF/ID first, also usable for ID/EX, EX/MEM).
// With SKID_EN = 1 a main + skid slot pair lets in_ready come straight
// from a flop, so there is no combinational path from out_ready back to
// in_ready. With SKID_EN = 0 only the main slot is used and in_ready is
// !out_valid | out_ready. A synchronous flush empties the register and
// drops any beat offered in the same cycle (a NOP bubble for redirects).
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   bus          pipe_reg_hs_if slave view: flush, in_* handshake and
//                beat, out_* handshake and beat, occupancy
module pipe_reg_hs
    import pipe_reg_hs_pkg::*;
#(
    parameter int                DATA_W  = LENGTH,
    parameter int                PC_W    = PC_LENGTH,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(INITIAL_VAL),
    parameter int                SKID_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    pipe_reg_hs_if.slave bus
);

    localparam int PCW = pc_width_eff(PC_W);

    occ_state_t        state_q;
    occ_state_t        state_d;
    logic              in_ready_q;
    logic              in_ready;
    logic              in_xfer;
    logic              out_xfer;

    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_src_data;
    logic [PCW-1:0]    main_src_pc;
    logic [PCW-1:0]    in_pc_eff;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [PCW-1:0]    main_pc;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [PCW-1:0]    skid_pc;

    // A removed PC field is forced to zero so out_pc can never carry junk.
    generate
        if (PC_W == 0) begin : g_no_pc
            assign in_pc_eff = '0;
        end else begin : g_pc
            assign in_pc_eff = bus.in_pc;
        end
    endgenerate

    // Skid mode uses the registered ready; flat mode must look at
    // out_ready combinationally to stream at full rate with one slot.
    assign in_ready = (SKID_EN != 0) ? in_ready_q : (!main_valid || bus.out_ready);

    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = main_valid && bus.out_ready;

    // Occupancy FSM register; in_ready_q is updated at the same edge so it
    // drops exactly when the register becomes full.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // Next-state and slot control. The main slot normally loads from the
    // input; when draining from TWO it takes the older beat from the skid
    // slot instead, which keeps delivery strictly in order.
    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        main_src_data = bus.in_data;
        main_src_pc   = in_pc_eff;

        if (bus.flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer && (SKID_EN != 0)) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d       = ST_ONE;
                        main_load     = 1'b1;
                        main_src_data = skid_data;
                        main_src_pc   = skid_pc;
                        skid_clear    = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PCW),
        .NOP_VAL (NOP_VAL)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_src_data),
        .load_pc   (main_src_pc),
        .valid     (main_valid),
        .data      (main_data),
        .pc        (main_pc)
    );

    pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PCW),
        .NOP_VAL (NOP_VAL)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (bus.in_data),
        .load_pc   (in_pc_eff),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_pc    = main_pc;
    assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Testbench for pipe_reg_hs: drives a skid instance (SKID_EN=1) and a
// flat instance (SKID_EN=0) with identical stimulus and compares each one
// against a queue-based model of a FIFO with capacity 2 or 1.
module tb_pipe_reg_hs;
    import pipe_reg_hs_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_reg_hs_if #(.DATA_W(32), .PC_W(32)) bus_skid ();
    pipe_reg_hs_if #(.DATA_W(32), .PC_W(32)) bus_flat ();

    pipe_reg_hs #(
        .DATA_W  (32),
        .PC_W    (32),
        .NOP_VAL (32'h0000_0000),
        .SKID_EN (1)
    ) dut_skid (
        .clk (clk),
        .rst (rst),
        .bus (bus_skid)
    );

    pipe_reg_hs #(
        .DATA_W  (32),
        .PC_W    (32),
        .NOP_VAL (32'h0000_0000),
        .SKID_EN (0)
    ) dut_flat (
        .clk (clk),
        .rst (rst),
        .bus (bus_flat)
    );

    int check_count = 0;
    int error_count = 0;

    // Model contents: each entry is {data, pc}, oldest at index 0.
    logic [63:0] model_skid[$];
    logic [63:0] model_flat[$];

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Compare one instance against what its model says it should show.
    task automatic checkInstance(input string name, input int size, input logic [63:0] head,
                                 input logic exp_ready, input logic act_ready,
                                 input logic act_valid, input logic [31:0] act_data,
                                 input logic [31:0] act_pc, input logic [1:0] act_occ);
        logic [63:0] shown;
        shown = (size > 0) ? head : {INITIAL_VAL, 32'h0};
        checkOutput({name, "_in_ready"},  64'(act_ready), 64'(exp_ready));
        checkOutput({name, "_out_valid"}, 64'(act_valid), 64'(size > 0));
        checkOutput({name, "_out_data"},  64'(act_data),  64'(shown[63:32]));
        checkOutput({name, "_out_pc"},    64'(act_pc),    64'(shown[31:0]));
        checkOutput({name, "_occupancy"}, 64'(act_occ),   64'(size));
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance
    // both models at the rising edge using the model's own ready.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [31:0] d, input logic [31:0] p,
                                 input logic orr, input bit do_check);
        logic ready_skid;
        logic ready_flat;
        logic [63:0] head_skid;
        logic [63:0] head_flat;

        rst                = r;
        bus_skid.flush     = f;
        bus_skid.in_valid  = iv;
        bus_skid.in_data   = d;
        bus_skid.in_pc     = p;
        bus_skid.out_ready = orr;
        bus_flat.flush     = f;
        bus_flat.in_valid  = iv;
        bus_flat.in_data   = d;
        bus_flat.in_pc     = p;
        bus_flat.out_ready = orr;
        #1;

        ready_skid = (model_skid.size() < 2);
        ready_flat = (model_flat.size() == 0) || orr;
        head_skid  = (model_skid.size() > 0) ? model_skid[0] : 64'h0;
        head_flat  = (model_flat.size() > 0) ? model_flat[0] : 64'h0;

        if (do_check) begin
            checkInstance("skid", model_skid.size(), head_skid, ready_skid, bus_skid.in_ready,
                          bus_skid.out_valid, bus_skid.out_data, bus_skid.out_pc,
                          bus_skid.occupancy);
            checkInstance("flat", model_flat.size(), head_flat, ready_flat, bus_flat.in_ready,
                          bus_flat.out_valid, bus_flat.out_data, bus_flat.out_pc,
                          bus_flat.occupancy);
        end

        @(posedge clk);
        if (r || f) begin
            model_skid.delete();
            model_flat.delete();
        end else begin
            if ((model_skid.size() > 0) && orr) void'(model_skid.pop_front());
            if (iv && ready_skid) model_skid.push_back({d, p});
            if ((model_flat.size() > 0) && orr) void'(model_flat.pop_front());
            if (iv && ready_flat) model_flat.push_back({d, p});
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held for two cycles with a beat offered; the first cycle
        // is unchecked because the registers are still unknown.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2002_0005, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2002_0005, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h11 * (i + 1), 32'(4 * i), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Backpressure: fill, hold A3 off, then release.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA1, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA2, 32'h104, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA3, 32'h108, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA3, 32'h108, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA3, 32'h108, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA3, 32'h108, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Flush while full, with a beat offered in the same cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hB1, 32'h200, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hB2, 32'h204, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hB3, 32'h208, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Reset and flush together mid-stream, then a fresh push.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hD1, 32'h300, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hD2, 32'h304, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hD3, 32'h308, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hC1, 32'h400, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Toggling out_ready under continuous input.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 32'hE0 + 32'(i), 32'h500 + 32'(4 * i),
                          (i % 2) == 0, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(63) == 0, $urandom_range(15) == 0,
                          $urandom_range(3) != 0, $urandom, $urandom,
                          $urandom_range(1) == 1, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
